// File: rtl/reward_calc_param_if.sv
// Memory read bus between the reward engine (master) and the shared memory (slave).
// mem_data returns the word for the address presented one clock earlier.
interface reward_calc_param_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] address;
  logic [WORD_WIDTH-1:0] mem_data;

  modport master (output address, input mem_data);
  modport slave  (input address, output mem_data);
endinterface

// File: rtl/reward_calc_param.sv
// Reward engine for the Q-learning router: four table reads through one port,
// then a hop or battery-weighted saturating reward with a one-cycle done pulse.
module reward_calc_param #(
  parameter int          WORD_WIDTH    = 16,
  parameter int unsigned NUM_NEIGHBORS = 64,
  parameter int unsigned NUM_HOPS      = 8,
  parameter int unsigned NID_BASE      = 'h0048,
  parameter int unsigned CID_BASE      = 'h00C8,
  parameter int unsigned BATT_BASE     = 'h0148,
  parameter int unsigned HOPM_BASE     = 'h0648,
  parameter int          BATT_SHIFT    = 8,
  parameter int unsigned INTRA_BONUS   = 10
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   en,
  input  logic                   start,
  input  logic                   mode,
  input  logic [WORD_WIDTH-1:0]  my_node_id,
  input  logic [WORD_WIDTH-1:0]  my_cluster_id,
  input  logic [WORD_WIDTH-1:0]  action,
  input  logic [WORD_WIDTH-1:0]  besthop,
  reward_calc_param_if.master    mem,
  output logic [WORD_WIDTH-1:0]  reward_out,
  output logic [WORD_WIDTH-1:0]  next_node,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    IDLE, A_NID, A_CID, A_BAT, A_HOP, W_HOP, CALC, DONE
  } state_t;

  state_t                state;
  logic                  start_seen;
  logic                  mode_q;
  logic [WORD_WIDTH-1:0] cluster_q;
  logic [WORD_WIDTH-1:0] node_id_q;
  logic [WORD_WIDTH-1:0] act_q;
  logic [WORD_WIDTH-1:0] hop_q;
  logic [WORD_WIDTH-1:0] cid_q;
  logic [WORD_WIDTH-1:0] batt_q;
  logic [WORD_WIDTH-1:0] hopm_q;

  // Caller node ID is held for future self-loop checks and not consumed yet.
  logic unused_node_id;
  assign unused_node_id = ^node_id_q;

  logic                  out_of_range;
  logic [WORD_WIDTH-1:0] hop_clamped;
  assign out_of_range = 32'(action) >= NUM_NEIGHBORS;
  assign hop_clamped  = (32'(besthop) > NUM_HOPS - 1) ? WORD_WIDTH'(NUM_HOPS - 1) : besthop;

  // Word tables use a 2-byte stride; the sum wraps at WORD_WIDTH.
  function automatic logic [WORD_WIDTH-1:0] table_addr(input int unsigned base,
                                                       input logic [WORD_WIDTH-1:0] idx);
    return WORD_WIDTH'(base) + {idx[WORD_WIDTH-2:0], 1'b0};
  endfunction

  logic [2*WORD_WIDTH-1:0] product;
  logic [2*WORD_WIDTH-1:0] scaled;
  logic [WORD_WIDTH-1:0]   base_reward;
  logic [WORD_WIDTH:0]     bonus_sum;
  logic [WORD_WIDTH-1:0]   reward_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    product     = {{WORD_WIDTH{1'b0}}, hopm_q} * {{WORD_WIDTH{1'b0}}, batt_q};
    scaled      = product >> BATT_SHIFT;
    base_reward = hopm_q;
    if (mode_q) begin
      base_reward = (|scaled[2*WORD_WIDTH-1:WORD_WIDTH]) ? '1 : scaled[WORD_WIDTH-1:0];
    end
    bonus_sum   = {1'b0, base_reward} + (WORD_WIDTH+1)'(INTRA_BONUS);
    reward_next = base_reward;
    if (cid_q == cluster_q) begin
      reward_next = bonus_sum[WORD_WIDTH] ? '1 : bonus_sum[WORD_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      mem.address <= '0;
      reward_out  <= '0;
      next_node   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      start_seen  <= 1'b0;
      mode_q      <= 1'b0;
      cluster_q   <= '0;
      node_id_q   <= '0;
      act_q       <= '0;
      hop_q       <= '0;
      cid_q       <= '0;
      batt_q      <= '0;
      hopm_q      <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      if (!start) start_seen <= 1'b0;

      case (state)
        IDLE: begin
          mem.address <= '0;
          if (start && !start_seen) begin
            start_seen <= 1'b1;
            mode_q     <= mode;
            cluster_q  <= my_cluster_id;
            node_id_q  <= my_node_id;
            act_q      <= action;
            hop_q      <= hop_clamped;
            if (out_of_range) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              err        <= 1'b1;
              reward_out <= '0;
              next_node  <= '0;
            end else begin
              state       <= A_NID;
              busy        <= 1'b1;
              err         <= 1'b0;
              mem.address <= table_addr(NID_BASE, action);
            end
          end
        end
        A_NID: begin
          state       <= A_CID;
          mem.address <= table_addr(CID_BASE, act_q);
        end
        A_CID: begin
          state       <= A_BAT;
          next_node   <= mem.mem_data;
          mem.address <= table_addr(BATT_BASE, act_q);
        end
        A_BAT: begin
          state       <= A_HOP;
          cid_q       <= mem.mem_data;
          mem.address <= table_addr(HOPM_BASE, hop_q);
        end
        A_HOP: begin
          state       <= W_HOP;
          batt_q      <= mem.mem_data;
          mem.address <= '0;
        end
        W_HOP: begin
          state  <= CALC;
          hopm_q <= mem.mem_data;
        end
        CALC: begin
          state      <= DONE;
          reward_out <= reward_next;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reward_calc_param.sv
// Directed bench for reward_calc_param: a reward model fills a scoreboard at each
// start and every done pulse is popped and compared with latency and address trace.
module tb_reward_calc_param;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         nreset = 1'b1;
  logic         en = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] my_node_id = '0;
  logic [W-1:0] my_cluster_id = '0;
  logic [W-1:0] action = '0;
  logic [W-1:0] besthop = '0;
  logic [W-1:0] reward_out;
  logic [W-1:0] next_node;
  logic         busy;
  logic         done;
  logic         err;

  reward_calc_param_if #(.WORD_WIDTH(W)) bus ();

  reward_calc_param #(.WORD_WIDTH(W)) dut (
    .clock         (clock),
    .nreset        (nreset),
    .en            (en),
    .start         (start),
    .mode          (mode),
    .my_node_id    (my_node_id),
    .my_cluster_id (my_cluster_id),
    .action        (action),
    .besthop       (besthop),
    .mem           (bus),
    .reward_out    (reward_out),
    .next_node     (next_node),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clock = ~clock;

  // Byte-addressed shared memory; it shares the engine's clock enable.
  logic [15:0] mem16 [0:4095];
  always @(posedge clock) if (en) bus.mem_data <= mem16[bus.address[11:0]];

  typedef struct {
    logic [15:0] reward;
    logic [15:0] nxt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_act = 0;
  int   cur_hop = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic m, input logic [15:0] cid,
                                 input logic [15:0] a, input logic [15:0] h);
    exp_t e;
    longint unsigned b;
    longint unsigned r;
    int ai;
    int hc;
    ai = int'(a);
    if (ai >= 64) begin
      e.reward = 16'h0;
      e.nxt    = 16'h0;
      e.err    = 1'b1;
      return e;
    end
    hc = (int'(h) > 7) ? 7 : int'(h);
    b  = longint'(mem16['h648 + 2*hc]);
    if (m) r = (b * longint'(mem16['h148 + 2*ai])) / 256;
    else   r = b;
    if (r > 65535) r = 65535;
    if (mem16['hC8 + 2*ai] == cid) r = r + 10;
    if (r > 65535) r = 65535;
    e.reward = 16'(r);
    e.nxt    = mem16['h48 + 2*ai];
    e.err    = 1'b0;
    return e;
  endfunction

  task automatic start_run(input logic m, input logic [15:0] cid,
                           input logic [15:0] a, input logic [15:0] h);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    mode          = m;
    my_cluster_id = cid;
    my_node_id    = 16'h0021;
    action        = a;
    besthop       = h;
    start         = 1'b1;
    cur_act       = int'(a);
    cur_hop       = (int'(h) > 7) ? 7 : int'(h);
    sb.push_back(model(m, cid, a, h));
  endtask

  task automatic collect(input string tag, input int exp_lat, input logic [15:0] exp_reward,
                         input int stall_at, input int stall_len);
    logic [15:0] trace[$];
    logic [15:0] want[$];
    logic [15:0] last;
    int          lat;
    exp_t        e;
    lat  = 0;
    last = 16'h0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 1) check({tag, "_busy"}, busy, exp_lat > 1);
      if (bus.address != last && bus.address != 16'h0) trace.push_back(bus.address);
      last = bus.address;
      if (stall_len > 0 && n == stall_at) en = 1'b0;
      if (stall_len > 0 && n == stall_at + stall_len) begin
        check({tag, "_stall_addr"}, bus.address, 16'(16'h148 + 2*cur_act));
        en = 1'b1;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_done_seen"}, lat != 0, 1);
    if (lat != 0) begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_reward_model"}, reward_out, e.reward);
        check({tag, "_next_node"}, next_node, e.nxt);
        check({tag, "_err"}, err, e.err);
      end
      check({tag, "_reward"}, reward_out, exp_reward);
      check({tag, "_busy_at_done"}, busy, 0);
      if (exp_lat > 1) begin
        want.push_back(16'(16'h48 + 2*cur_act));
        want.push_back(16'(16'hC8 + 2*cur_act));
        want.push_back(16'(16'h148 + 2*cur_act));
        want.push_back(16'(16'h648 + 2*cur_hop));
      end
      check({tag, "_trace_len"}, trace.size(), want.size());
      for (int i = 0; i < trace.size() && i < want.size(); i++)
        check($sformatf("%s_addr%0d", tag, i), trace[i], want[i]);
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    check({tag, "_no_rerun"}, cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem16[i] = 16'h0;
    mem16['h4E]  = 16'd7;
    mem16['hCE]  = 16'd5;
    mem16['h14E] = 16'd128;
    mem16['h650] = 16'd100;
    mem16['h656] = 16'd33;

    #2 nreset = 1'b0;
    @(negedge clock);
    check("reset_outs", {bus.address, reward_out, next_node, busy, done, err}, 0);
    nreset = 1'b1;

    start_run(1'b0, 16'd5, 16'd3, 16'd4);
    collect("hop_same", 7, 16'd110, 0, 0);
    quiet("hop_same", 12);

    start_run(1'b1, 16'd5, 16'd3, 16'd4);
    collect("batt_same", 7, 16'd60, 0, 0);
    quiet("batt_same", 10);

    start_run(1'b0, 16'd6, 16'd3, 16'd4);
    collect("hop_other", 7, 16'd100, 0, 0);
    start_run(1'b1, 16'd6, 16'd3, 16'd4);
    collect("batt_other", 7, 16'd50, 0, 0);

    mem16['h650] = 16'hFFFA;
    start_run(1'b0, 16'd5, 16'd3, 16'd4);
    collect("sat_bonus", 7, 16'hFFFF, 0, 0);
    mem16['h14E] = 16'hFFFF;
    start_run(1'b1, 16'd5, 16'd3, 16'd4);
    collect("sat_product", 7, 16'hFFFF, 0, 0);
    mem16['h650] = 16'd100;
    mem16['h14E] = 16'd128;

    start_run(1'b0, 16'd5, 16'd64, 16'd4);
    collect("out_of_range", 1, 16'd0, 0, 0);
    quiet("out_of_range", 6);

    start_run(1'b0, 16'd5, 16'd3, 16'd20);
    collect("hop_clamp", 7, 16'd43, 0, 0);

    start_run(1'b0, 16'd5, 16'd3, 16'd4);
    collect("stall", 12, 16'd110, 3, 5);

    start_run(1'b0, 16'd5, 16'd3, 16'd4);
    for (int n = 1; n <= 4; n++) @(negedge clock);
    check("rst_mid_addr", bus.address, 16'h650);
    nreset = 1'b0;
    #1;
    check("rst_mid_outs", {bus.address, reward_out, next_node, busy, done, err}, 0);
    sb.delete();
    repeat (3) @(negedge clock);
    check("rst_hold_outs", {bus.address, reward_out, next_node, busy, done, err}, 0);
    nreset = 1'b1;
    sb.push_back(model(1'b0, 16'd5, 16'd3, 16'd4));
    collect("rst_rerun", 7, 16'd110, 0, 0);
    quiet("rst_rerun", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
